// File: rtl/svc_rv_fwd_sb.sv
// svc_rv_fwd_sb: operand forwarding and long-latency scoreboard for the EX stage.
// Forwards MEM/WB results to up to NSRC operands, tracks registers owned by
// in-flight long-latency ops, and raises stall_ex on hazards it cannot forward.
module svc_rv_fwd_sb #(
  parameter int XLEN     = 32,
  parameter int NSRC     = 2,
  parameter int FWD      = 1,
  parameter int MEM_TYPE = 0,
  parameter int MAX_PEND = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC*5-1:0]    rs_ex,
  input  logic [NSRC-1:0]      rs_used_ex,
  input  logic [NSRC*XLEN-1:0] rs_data_ex,
  input  logic [4:0]           rd_mem,
  input  logic                 reg_write_mem,
  input  logic                 is_load_mem,
  input  logic                 is_csr_mem,
  input  logic [XLEN-1:0]      alu_result_mem,
  input  logic [XLEN-1:0]      load_data_mem,
  input  logic [4:0]           rd_wb,
  input  logic                 reg_write_wb,
  input  logic [XLEN-1:0]      rd_data,
  input  logic                 ll_issue,
  input  logic [4:0]           ll_rd,
  input  logic                 ll_done,
  input  logic [4:0]           ll_done_rd,
  output logic [NSRC*XLEN-1:0] rs_fwd_ex,
  output logic                 stall_ex,
  output logic [4:0]           pend_cnt,
  output logic [31:0]          stall_cnt,
  output logic                 sb_err
);

  localparam bit FWD_EN    = (FWD != 0);
  localparam bit SRAM_LOAD = (MEM_TYPE == 1);
  localparam logic [4:0] PEND_MAX = 5'(MAX_PEND);

  logic [31:0]     sb;
  logic [31:0]     sb_nxt;
  logic [NSRC-1:0] slot_stall;
  logic            issue_stall;
  logic            issue_acc;
  logic            done_ok;

  for (genvar g = 0; g < NSRC; g++) begin : g_slot
    logic [4:0]      rs;
    logic            mem_hit;
    logic            wb_hit;
    logic            sb_hit;
    logic [XLEN-1:0] fwd;

    assign rs      = rs_ex[5*g +: 5];
    assign mem_hit = reg_write_mem && (rd_mem != 5'd0) && (rd_mem == rs);
    assign wb_hit  = reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rs);
    // A register whose long-latency result lands on WB this cycle is no longer busy.
    assign sb_hit  = sb[rs] && !(ll_done && (ll_done_rd == rs));

    // Priority operand select: SRAM load in MEM, then MEM ALU, then WB, then regfile.
    always_comb begin
      // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
      fwd = rs_data_ex[g*XLEN +: XLEN];
      if (FWD_EN) begin
        if (SRAM_LOAD && mem_hit && is_load_mem)
          fwd = load_data_mem;
        else if (mem_hit && !is_load_mem && !is_csr_mem)
          fwd = alu_result_mem;
        else if (wb_hit)
          fwd = rd_data;
      end
    end

    assign rs_fwd_ex[g*XLEN +: XLEN] = fwd;

    assign slot_stall[g] = rs_used_ex[g] && (rs != 5'd0) &&
                           (sb_hit ||
                            (mem_hit && (is_csr_mem || (is_load_mem && !SRAM_LOAD))) ||
                            (!FWD_EN && (mem_hit || wb_hit)));
  end

  // Capacity hold and WAW hold on the destination of a new long-latency op.
  assign issue_stall = ll_issue &&
                       ((pend_cnt == PEND_MAX) ||
                        (sb[ll_rd] && !(ll_done && (ll_done_rd == ll_rd))));

  assign stall_ex  = (|slot_stall) || issue_stall;
  assign issue_acc = ll_issue && !stall_ex && (ll_rd != 5'd0);
  assign done_ok   = ll_done && sb[ll_done_rd];

  // Next scoreboard: clear the completing register, then set the issuing one so set wins.
  always_comb begin
    sb_nxt = sb;
    if (done_ok)
      sb_nxt[ll_done_rd] = 1'b0;
    if (issue_acc)
      sb_nxt[ll_rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  // Scoreboard, pending count, stall counter and sticky error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb        <= '0;
      pend_cnt  <= '0;
      stall_cnt <= '0;
      sb_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sb <= sb_nxt;
      case ({issue_acc, done_ok})
        2'b10:   pend_cnt <= pend_cnt + 5'd1;
        2'b01:   pend_cnt <= pend_cnt - 5'd1;
        default: pend_cnt <= pend_cnt;
      endcase
      if (stall_ex && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (ll_done && !done_ok)
        sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_svc_rv_fwd_sb.sv
// Directed bench for svc_rv_fwd_sb: three instances share stimulus
// (a: BRAM/MAX_PEND=4, b: SRAM/MAX_PEND=2, c: forwarding disabled).
module tb_svc_rv_fwd_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rs_ex;
  logic [1:0]  rs_used_ex;
  logic [63:0] rs_data_ex;
  logic [4:0]  rd_mem;
  logic        reg_write_mem, is_load_mem, is_csr_mem;
  logic [31:0] alu_result_mem, load_data_mem;
  logic [4:0]  rd_wb;
  logic        reg_write_wb;
  logic [31:0] rd_data;
  logic        ll_issue, ll_done;
  logic [4:0]  ll_rd, ll_done_rd;

  logic [63:0] fwd_a, fwd_b, fwd_c;
  logic        stall_a, stall_b, stall_c;
  logic [4:0]  pend_a, pend_b, pend_c;
  logic [31:0] scnt_a, scnt_b, scnt_c;
  logic        err_a, err_b, err_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  svc_rv_fwd_sb #(.MEM_TYPE(0), .MAX_PEND(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .rs_ex(rs_ex), .rs_used_ex(rs_used_ex), .rs_data_ex(rs_data_ex),
    .rd_mem(rd_mem), .reg_write_mem(reg_write_mem), .is_load_mem(is_load_mem), .is_csr_mem(is_csr_mem),
    .alu_result_mem(alu_result_mem), .load_data_mem(load_data_mem),
    .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .rd_data(rd_data),
    .ll_issue(ll_issue), .ll_rd(ll_rd), .ll_done(ll_done), .ll_done_rd(ll_done_rd),
    .rs_fwd_ex(fwd_a), .stall_ex(stall_a), .pend_cnt(pend_a), .stall_cnt(scnt_a), .sb_err(err_a));

  svc_rv_fwd_sb #(.MEM_TYPE(1), .MAX_PEND(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rs_ex(rs_ex), .rs_used_ex(rs_used_ex), .rs_data_ex(rs_data_ex),
    .rd_mem(rd_mem), .reg_write_mem(reg_write_mem), .is_load_mem(is_load_mem), .is_csr_mem(is_csr_mem),
    .alu_result_mem(alu_result_mem), .load_data_mem(load_data_mem),
    .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .rd_data(rd_data),
    .ll_issue(ll_issue), .ll_rd(ll_rd), .ll_done(ll_done), .ll_done_rd(ll_done_rd),
    .rs_fwd_ex(fwd_b), .stall_ex(stall_b), .pend_cnt(pend_b), .stall_cnt(scnt_b), .sb_err(err_b));

  svc_rv_fwd_sb #(.FWD(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .rs_ex(rs_ex), .rs_used_ex(rs_used_ex), .rs_data_ex(rs_data_ex),
    .rd_mem(rd_mem), .reg_write_mem(reg_write_mem), .is_load_mem(is_load_mem), .is_csr_mem(is_csr_mem),
    .alu_result_mem(alu_result_mem), .load_data_mem(load_data_mem),
    .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .rd_data(rd_data),
    .ll_issue(ll_issue), .ll_rd(ll_rd), .ll_done(ll_done), .ll_done_rd(ll_done_rd),
    .rs_fwd_ex(fwd_c), .stall_ex(stall_c), .pend_cnt(pend_c), .stall_cnt(scnt_c), .sb_err(err_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs_ex = '0; rs_used_ex = '0; rs_data_ex = {32'h0000_BBBB, 32'h0000_AAAA};
    rd_mem = '0; reg_write_mem = 0; is_load_mem = 0; is_csr_mem = 0;
    alu_result_mem = '0; load_data_mem = '0;
    rd_wb = '0; reg_write_wb = 0; rd_data = '0;
    ll_issue = 0; ll_rd = '0; ll_done = 0; ll_done_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    #1;
    check("rst_pend", {27'd0, pend_a}, 32'd0);
    check("rst_scnt", scnt_a, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    check("init_pend", {27'd0, pend_a}, 32'd0);
    check("init_scnt", scnt_a, 32'd0);
    check("init_err", {31'd0, err_a}, 32'd0);
    check("init_stall", {31'd0, stall_a}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // MEM ALU beats WB; disabled forwarding passes regfile data and stalls.
    idle();
    rs_ex[4:0] = 5'd5; rs_used_ex = 2'b01;
    rd_mem = 5'd5; reg_write_mem = 1; alu_result_mem = 32'h11;
    rd_wb = 5'd5; reg_write_wb = 1; rd_data = 32'h22;
    #1;
    check("mem_alu_a", fwd_a[31:0], 32'h11);
    check("mem_alu_stall_a", {31'd0, stall_a}, 32'd0);
    check("mem_alu_b", fwd_b[31:0], 32'h11);
    check("nofwd_data_c", fwd_c[31:0], 32'h0000_AAAA);
    check("nofwd_stall_c", {31'd0, stall_c}, 32'd1);
    check("slot1_pass_a", fwd_a[63:32], 32'h0000_BBBB);
    reg_write_mem = 0;
    #1;
    check("wb_only_a", fwd_a[31:0], 32'h22);
    reg_write_mem = 1; is_csr_mem = 1;
    #1;
    check("csr_stall_a", {31'd0, stall_a}, 32'd1);
    check("csr_skip_a", fwd_a[31:0], 32'h22);
    rs_ex[4:0] = 5'd0; rd_mem = 5'd0; rd_wb = 5'd0;
    #1;
    check("x0_data_a", fwd_a[31:0], 32'h0000_AAAA);
    check("x0_stall_a", {31'd0, stall_a}, 32'd0);

    // Load in MEM: BRAM stalls, SRAM forwards.
    do_reset();
    rs_ex[9:5] = 5'd7; rs_used_ex = 2'b10;
    rd_mem = 5'd7; reg_write_mem = 1; is_load_mem = 1;
    load_data_mem = 32'hAB; alu_result_mem = 32'h55;
    #1;
    check("load_stall_a", {31'd0, stall_a}, 32'd1);
    check("load_fwd_b", fwd_b[63:32], 32'hAB);
    check("load_stall_b", {31'd0, stall_b}, 32'd0);
    tick();
    check("load_scnt_a", scnt_a, 32'd1);
    check("load_scnt_b", scnt_b, 32'd0);

    // Long-latency RAW on x3, released by completion with WB data.
    do_reset();
    ll_issue = 1; ll_rd = 5'd3;
    #1;
    check("ll3_issue_stall", {31'd0, stall_a}, 32'd0);
    tick();
    check("ll3_pend", {27'd0, pend_a}, 32'd1);
    idle();
    rs_ex[4:0] = 5'd3; rs_used_ex = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("raw_stall", {31'd0, stall_a}, 32'd1);
      tick();
    end
    check("raw_scnt", scnt_a, 32'd4);
    ll_done = 1; ll_done_rd = 5'd3; reg_write_wb = 1; rd_wb = 5'd3; rd_data = 32'h99;
    #1;
    check("done_fwd", fwd_a[31:0], 32'h99);
    check("done_stall", {31'd0, stall_a}, 32'd0);
    tick();
    check("done_pend", {27'd0, pend_a}, 32'd0);
    check("done_scnt", scnt_a, 32'd4);

    // Capacity hold on b, WAW hold on a, same-register done+issue.
    do_reset();
    ll_issue = 1; ll_rd = 5'd1; tick();
    ll_rd = 5'd2; tick();
    check("cap_pend_b", {27'd0, pend_b}, 32'd2);
    ll_rd = 5'd4;
    #1;
    check("cap_stall_b", {31'd0, stall_b}, 32'd1);
    check("cap_nostall_a", {31'd0, stall_a}, 32'd0);
    tick();
    check("cap_hold_b", {27'd0, pend_b}, 32'd2);
    check("cap_pend_a", {27'd0, pend_a}, 32'd3);
    ll_done = 1; ll_done_rd = 5'd1;
    #1;
    check("cap_done_stall_b", {31'd0, stall_b}, 32'd1);
    check("waw_stall_a", {31'd0, stall_a}, 32'd1);
    tick();
    check("cap_dec_b", {27'd0, pend_b}, 32'd1);
    check("waw_dec_a", {27'd0, pend_a}, 32'd2);
    ll_done = 0;
    #1;
    check("cap_free_b", {31'd0, stall_b}, 32'd0);
    tick();
    check("cap_acc_b", {27'd0, pend_b}, 32'd2);
    check("waw_hold_a", {27'd0, pend_a}, 32'd2);
    ll_rd = 5'd2; ll_done = 1; ll_done_rd = 5'd2;
    #1;
    check("same_reg_stall_a", {31'd0, stall_a}, 32'd0);
    check("same_reg_stall_b", {31'd0, stall_b}, 32'd1);
    tick();
    check("same_reg_pend_a", {27'd0, pend_a}, 32'd2);
    check("same_reg_pend_b", {27'd0, pend_b}, 32'd1);
    idle();
    rs_ex[4:0] = 5'd2; rs_used_ex = 2'b01;
    #1;
    check("set_wins_a", {31'd0, stall_a}, 32'd1);
    check("cleared_b", {31'd0, stall_b}, 32'd0);
    tick();
    check("waw_scnt_a", scnt_a, 32'd3);
    check("cap_scnt_b", scnt_b, 32'd3);
    check("no_err_a", {31'd0, err_a}, 32'd0);

    // Spurious completion, then asynchronous reset with ops pending.
    idle();
    ll_done = 1; ll_done_rd = 5'd9;
    tick();
    check("err_a", {31'd0, err_a}, 32'd1);
    check("err_b", {31'd0, err_b}, 32'd1);
    check("err_pend_a", {27'd0, pend_a}, 32'd2);
    check("err_pend_b", {27'd0, pend_b}, 32'd1);
    idle();
    ll_issue = 1; ll_rd = 5'd6;
    tick();
    check("pre_rst_pend_a", {27'd0, pend_a}, 32'd3);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_pend_a", {27'd0, pend_a}, 32'd0);
    check("arst_err_a", {31'd0, err_a}, 32'd0);
    check("arst_scnt_a", scnt_a, 32'd0);
    check("arst_pend_b", {27'd0, pend_b}, 32'd0);
    #3 rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
